// File: rtl/pulse_width_detector.sv
// Multi-channel edge and pulse-width detector.
// Flags edges and pulses of one polarity whose length lies in [min_len, max_len].
module pulse_width_detector #(
   parameter int CHANNELS = 8,
   parameter int CNT_W    = 4,
   parameter bit REG_OUT  = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] a,
   input  logic [1:0]          edge_sel,
   input  logic                pulse_pol,
   input  logic [CNT_W-1:0]    min_len,
   input  logic [CNT_W-1:0]    max_len,
   input  logic [CHANNELS-1:0] clr,
   output logic [CHANNELS-1:0] edge_det,
   output logic [CHANNELS-1:0] pulse_det,
   output logic [CHANNELS-1:0] pulse_seen
);

   localparam logic [CNT_W-1:0] MAXV = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CHANNELS-1:0] a_r;
   logic [CNT_W-1:0]    run_len [CHANNELS];
   logic                pol_r;

   logic [CHANNELS-1:0] act_vec;
   logic [CHANNELS-1:0] a_act;
   logic [CHANNELS-1:0] ar_act;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] edge_raw;
   logic [CHANNELS-1:0] hit;
   logic                pol_chg;
   logic [CNT_W-1:0]    eff_min;

   assign act_vec = {CHANNELS{~pulse_pol}};
   assign a_act   = ~(a ^ act_vec);
   assign ar_act  = ~(a_r ^ act_vec);
   assign rise    = ~a_r & a;
   assign fall    = a_r & ~a;
   assign pol_chg = pulse_pol ^ pol_r;
   assign eff_min = (min_len == '0) ? ONE : min_len;

   // Pick the edge type requested by edge_sel; 11 disables edge reporting.
   always_comb begin
      edge_raw = '0;
      case (edge_sel)
         2'b00:   edge_raw = rise;
         2'b01:   edge_raw = fall;
         2'b10:   edge_raw = rise | fall;
         default: edge_raw = '0;
      endcase
   end

   // A run ends on the first inactive sample; qualify its length.
   // A polarity switch discards whatever run was being tracked.
   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i] = ar_act[i] & ~a_act[i]
                & (run_len[i] >= eff_min)
                & (run_len[i] <= max_len)
                & ~pol_chg;
      end
   end

   // Track previous sample, polarity and saturating run length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r   <= '0;
         pol_r <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            run_len[i] <= '0;
         end
      end else begin
         a_r   <= a;
         pol_r <= pulse_pol;
         for (int i = 0; i < CHANNELS; i++) begin
            if (pol_chg) begin
               run_len[i] <= '0;
            end else if (a_act[i]) begin
               if (ar_act[i]) begin
                  run_len[i] <= (run_len[i] == MAXV) ? MAXV
                              : run_len[i] + ONE;
               end else begin
                  run_len[i] <= ONE;
               end
            end else begin
               run_len[i] <= '0;
            end
         end
      end
   end

   // Sticky flag: a new hit wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pulse_seen <= '0;
      end else begin
         pulse_seen <= (pulse_seen & ~clr) | hit;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [CHANNELS-1:0] edge_q;
         logic [CHANNELS-1:0] pulse_q;

         // Retime detect outputs by one cycle.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               edge_q  <= '0;
               pulse_q <= '0;
            end else begin
               edge_q  <= edge_raw;
               pulse_q <= hit;
            end
         end

         assign edge_det  = edge_q;
         assign pulse_det = pulse_q;
      end else begin : g_comb
         assign edge_det  = edge_raw;
         assign pulse_det = hit;
      end
   endgenerate

endmodule
